sp_link_ctrl: RTL and testbench
===============================

SP_LINK_CTRL -- requirements
Module: sp_link_ctrl

Interface
REQ-001 The block SHALL have parameter COMMA, default 8'hBC, meaning the idle/alignment byte.
REQ-002 The block SHALL have parameter SYNC_CNT, default 4, meaning the consecutive COMMA bytes needed to go active; legal range 2..15.
REQ-003 The block SHALL have parameter LOSS_CNT, default 3, meaning the consecutive invalid cycles in ACTIVE that drop sync; legal range 1..15.
REQ-004 clk_4f  input  1  The single clock; all state updates on its rising edge.
REQ-005 reset_L  input  1  Asynchronous, active-low reset.
REQ-006 enable  input  1  Link enable; 0 forces IDLE.
REQ-007 data_in  input  8  Parallel byte from the serial-parallel converter.
REQ-008 valid_in  input  1  data_in qualifier.
REQ-009 data_out  output  8  Payload byte, registered.
REQ-010 valid_out  output  1  data_out qualifier, registered.
REQ-011 active  output  1  Link synchronized; equals (state == ACTIVE).
REQ-012 state  output  2  Current FSM state: IDLE=0, SEARCH=1, ALIGN=2, ACTIVE=3.
REQ-013 err_count  output  8  Saturating count of invalid cycles seen while in ACTIVE.

Function
REQ-014 The FSM SHALL move from any state to IDLE on the next edge when enable=0; this has priority over all other transitions.
REQ-015 IDLE SHALL go to SEARCH on the next edge when enable=1.
REQ-016 SEARCH SHALL go to ALIGN with comma counter=1 when valid_in=1 and data_in=COMMA; otherwise it stays in SEARCH.
REQ-017 In ALIGN, each valid COMMA SHALL increment the comma counter; the SYNC_CNT-th consecutive COMMA SHALL move the FSM to ACTIVE.
REQ-018 In ALIGN, a valid non-COMMA byte or a valid_in=0 cycle SHALL return the FSM to SEARCH and clear the comma counter.
REQ-019 active SHALL rise on the edge that samples the SYNC_CNT-th COMMA, so it is high from the following cycle.
REQ-020 In ACTIVE, valid non-COMMA bytes SHALL appear on data_out with valid_out=1 exactly one cycle later (latency 1).
REQ-021 In ACTIVE, a valid COMMA SHALL be stripped: valid_out=0 and the miss counter cleared.
REQ-022 In ACTIVE, each valid_in=0 cycle SHALL increment the miss counter and err_count; any valid_in=1 cycle SHALL clear the miss counter.
REQ-023 The LOSS_CNT-th consecutive miss SHALL move the FSM to SEARCH; active=0 from the next cycle.
REQ-024 err_count SHALL saturate at 255 and clear only on reset; it counts only in ACTIVE.
REQ-025 Outside ACTIVE, valid_out SHALL be 0 and data_out SHALL hold its last value.
REQ-026 The first valid byte sampled in ACTIVE SHALL be treated as payload or idle; the COMMA that caused entry SHALL NOT be forwarded.
REQ-027 A reset that occurs mid-payload SHALL drop the in-flight byte; no partial output is produced.

Reset
REQ-028 While reset_L=0, the block SHALL immediately force: state=IDLE, active=0, valid_out=0, data_out=8'h00, err_count=0, comma counter=0, miss counter=0.
REQ-029 After reset_L is released, the first transition SHALL occur on the next rising clk_4f edge.

Verification
REQ-030 Scenario: reset_L=0 at any time -> all outputs 0 and state=0, asynchronously.
REQ-031 Scenario: enable=1; 4 valid 0xBC; then 0x55 -> active=1 after the 4th BC edge; data_out=0x55 with valid_out=1 one cycle after 0x55 is sampled; BCs are never output.
REQ-032 Scenario: 3 x 0xBC, then 0x12 -> state returns to SEARCH and active stays 0; a further 4 x 0xBC -> ACTIVE.
REQ-033 Scenario: in ACTIVE, valid_in=0 for 2 cycles, then byte 0xA7 -> stays active, err_count=2, 0xA7 is output; then valid_in=0 for 3 cycles -> active=0, state=SEARCH, err_count=5.
REQ-034 Scenario: enable=0 during an ACTIVE payload stream -> state=IDLE and active=0 on the next edge, valid_out=0, data_out holds its last value.
REQ-035 Scenario: 300 invalid cycles in ACTIVE with LOSS_CNT=15, interleaved with valid bytes every 10 cycles -> err_count saturates at 255 and does not wrap.

Source files
------------

// File: rtl/sp_link_ctrl.sv
// Serial-parallel link controller: comma-based alignment, payload forwarding,
// loss-of-sync detection and a saturating error counter.
module sp_link_ctrl #(
  parameter logic [7:0] COMMA    = 8'hBC,
  parameter int         SYNC_CNT = 4,
  parameter int         LOSS_CNT = 3
) (
  input  logic       clk_4f,
  input  logic       reset_L,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic [1:0] state,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    ALIGN  = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  localparam logic [3:0] SYNC_N = 4'(SYNC_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  state_t     state_reg, state_next;
  logic [3:0] comma_cnt_reg, comma_cnt_next;
  logic [3:0] miss_cnt_reg, miss_cnt_next;
  logic [7:0] err_cnt_reg, err_cnt_next;
  logic [7:0] data_out_reg, data_out_next;
  logic       valid_out_reg, valid_out_next;

  logic is_comma;
  assign is_comma = valid_in && (data_in == COMMA);

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_reg     <= IDLE;
      comma_cnt_reg <= 4'd0;
      miss_cnt_reg  <= 4'd0;
      err_cnt_reg   <= 8'd0;
      data_out_reg  <= 8'd0;
      valid_out_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      comma_cnt_reg <= comma_cnt_next;
      miss_cnt_reg  <= miss_cnt_next;
      err_cnt_reg   <= err_cnt_next;
      data_out_reg  <= data_out_next;
      valid_out_reg <= valid_out_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    comma_cnt_next = comma_cnt_reg;
    miss_cnt_next  = miss_cnt_reg;
    err_cnt_next   = err_cnt_reg;
    data_out_next  = data_out_reg;
    valid_out_next = 1'b0;

    if (!enable) begin
      state_next     = IDLE;
      comma_cnt_next = 4'd0;
      miss_cnt_next  = 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next     = SEARCH;
          comma_cnt_next = 4'd0;
          miss_cnt_next  = 4'd0;
        end
        SEARCH: begin
          if (is_comma) begin
            state_next     = ALIGN;
            comma_cnt_next = 4'd1;
          end
        end
        ALIGN: begin
          if (is_comma) begin
            if (comma_cnt_reg + 4'd1 == SYNC_N) begin
              state_next     = ACTIVE;
              comma_cnt_next = 4'd0;
              miss_cnt_next  = 4'd0;
            end else begin
              comma_cnt_next = comma_cnt_reg + 4'd1;
            end
          end else begin
            // Any break in the comma run, including an idle cycle, restarts the hunt.
            state_next     = SEARCH;
            comma_cnt_next = 4'd0;
          end
        end
        ACTIVE: begin
          if (valid_in) begin
            miss_cnt_next = 4'd0;
            if (data_in != COMMA) begin
              data_out_next  = data_in;
              valid_out_next = 1'b1;
            end
          end else begin
            if (err_cnt_reg != 8'hFF) begin
              err_cnt_next = err_cnt_reg + 8'd1;
            end
            if (miss_cnt_reg + 4'd1 == LOSS_N) begin
              state_next    = SEARCH;
              miss_cnt_next = 4'd0;
            end else begin
              miss_cnt_next = miss_cnt_reg + 4'd1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign data_out  = data_out_reg;
  assign valid_out = valid_out_reg;
  assign active    = (state_reg == ACTIVE);
  assign state     = state_reg;
  assign err_count = err_cnt_reg;

endmodule

// File: tb/tb_sp_link_ctrl.sv
// Directed bench for sp_link_ctrl: scoreboard queue for payload bytes plus
// direct checks of state, active and err_count after each scenario step.
module tb_sp_link_ctrl;

  logic       clk_4f;
  logic       reset_L;
  logic       enable;
  logic [7:0] data_in;
  logic       valid_in;

  logic [7:0] data_out, data_out2;
  logic       valid_out, valid_out2;
  logic       active, active2;
  logic [1:0] state, state2;
  logic [7:0] err_count, err_count2;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  sp_link_ctrl dut (
    .clk_4f(clk_4f), .reset_L(reset_L), .enable(enable),
    .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out), .valid_out(valid_out), .active(active),
    .state(state), .err_count(err_count)
  );

  sp_link_ctrl #(.LOSS_CNT(15)) dut_sat (
    .clk_4f(clk_4f), .reset_L(reset_L), .enable(enable),
    .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out2), .valid_out(valid_out2), .active(active2),
    .state(state2), .err_count(err_count2)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic commas(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 8'hBC);
  endtask

  // Monitor: every presented payload byte must match the head of the queue.
  initial begin
    forever begin
      @(negedge clk_4f);
      if (valid_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got %0h expected none", data_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data_out != e) begin
            errors++;
            $display("FAIL payload got %0h expected %0h", data_out, e);
          end else begin
            $display("ok   payload = %0h", data_out);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_L  = 1'b0;
    enable   = 1'b0;
    data_in  = 8'h00;
    valid_in = 1'b0;
    #3;
    chk("rst_state", state, 0);
    chk("rst_active", active, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_err", err_count, 0);
    #9 reset_L = 1'b1;

    // Bring-up: IDLE -> SEARCH, then 4 commas to ACTIVE, then payload 0x55.
    enable = 1'b1;
    step(1'b0, 8'h00);
    chk("idle_to_search", state, 1);
    step(1'b1, 8'hBC);
    chk("search_to_align", state, 2);
    commas(2);
    chk("align_3_commas_active", active, 0);
    commas(1);
    chk("sync_state", state, 3);
    chk("sync_active", active, 1);
    chk("sync_comma_not_fwd", valid_out, 0);
    exp_q.push_back(8'h55);
    step(1'b1, 8'h55);
    chk("payload_valid", valid_out, 1);
    step(1'b1, 8'hBC);
    chk("comma_stripped", valid_out, 0);

    // Misses: 2 idle cycles, a payload, then 3 idle cycles drop sync.
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("miss2_active", active, 1);
    chk("miss2_err", err_count, 2);
    exp_q.push_back(8'hA7);
    step(1'b1, 8'hA7);
    chk("after_a7_err", err_count, 2);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("miss_2of3_active", active, 1);
    step(1'b0, 8'h00);
    chk("loss_state", state, 1);
    chk("loss_active", active, 0);
    chk("loss_err", err_count, 5);

    // Broken comma run returns to SEARCH; a full run then syncs.
    commas(3);
    step(1'b1, 8'h12);
    chk("broken_run_state", state, 1);
    chk("broken_run_active", active, 0);
    commas(4);
    chk("resync_state", state, 3);

    // Disable mid-stream: IDLE next edge, data_out holds last payload.
    exp_q.push_back(8'h31);
    step(1'b1, 8'h31);
    enable = 1'b0;
    step(1'b1, 8'h32);
    chk("disable_state", state, 0);
    chk("disable_active", active, 0);
    chk("disable_valid_out", valid_out, 0);
    chk("disable_data_hold", data_out, 8'h31);
    step(1'b0, 8'h00);
    chk("disable_data_hold2", data_out, 8'h31);

    // Asynchronous reset while a payload byte is waiting to be sampled.
    enable = 1'b1;
    step(1'b0, 8'h00);
    commas(4);
    chk("pre_reset_active", active, 1);
    data_in  = 8'h66;
    valid_in = 1'b1;
    #2 reset_L = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_active", active, 0);
    chk("async_data_out", data_out, 0);
    chk("async_err", err_count, 0);
    @(posedge clk_4f);
    #1;
    chk("in_reset_valid_out", valid_out, 0);
    #2 reset_L = 1'b1;
    step(1'b0, 8'h00);
    chk("post_reset_first_edge", state, 1);
    chk("post_reset_data_out", data_out, 0);

    // Saturation: both instances sync; the LOSS_CNT=15 one stays ACTIVE.
    commas(4);
    chk("sat_dut_active", active2, 1);
    for (int i = 0; i < 334; i++) begin
      if (i % 10 == 9) step(1'b1, 8'h77);
      else step(1'b0, 8'h00);
    end
    chk("sat_err", err_count2, 255);
    chk("sat_state", state2, 3);
    chk("base_dut_loss_state", state, 1);
    chk("base_dut_err", err_count, 3);

    @(negedge clk_4f);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
